// File: rtl/tx_stream_arbiter.sv
// Packet-granular two-port arbiter onto the MAC TX stream: one-cycle grant latency, then a zero-latency pass-through.
// Backpressure: m_axis_tready reaches only the owning source; the idle port and every GAP cycle see tready=0.
module tx_stream_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int IFG_CYCLES    = 4,
  parameter int MAX_S0_STREAK = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                  gtx_clk_bufg,
  input  logic                  gtx_reset,
  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic                  s0_axis_tvalid,
  input  logic                  s0_axis_tlast,
  output logic                  s0_axis_tready,
  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic                  s1_axis_tvalid,
  input  logic                  s1_axis_tlast,
  output logic                  s1_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [1:0]            grant,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  pkt_cnt0,
  output logic [CNT_WIDTH-1:0]  pkt_cnt1
);

  localparam int SW = $clog2(MAX_S0_STREAK + 1);
  localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_S0_STREAK);
  localparam logic [GW-1:0] GAP_LOAD   = (IFG_CYCLES > 0) ? GW'(IFG_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic [GW-1:0] gap_cnt;
  logic          s0_last_hs;
  logic          s1_last_hs;

  assign s0_last_hs = (state == GRANT0) && s0_axis_tvalid && m_axis_tready && s0_axis_tlast;
  assign s1_last_hs = (state == GRANT1) && s1_axis_tvalid && m_axis_tready && s1_axis_tlast;

  // Pure pass-through from the owning port; everything else is held at zero.
  always_comb begin
    m_axis_tdata   = '0;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    case (state)
      GRANT0: begin
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tvalid  = s0_axis_tvalid;
        m_axis_tlast   = s0_axis_tlast;
        s0_axis_tready = m_axis_tready;
      end
      GRANT1: begin
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tvalid  = s1_axis_tvalid;
        m_axis_tlast   = s1_axis_tlast;
        s1_axis_tready = m_axis_tready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge gtx_clk_bufg or posedge gtx_reset) begin
    if (gtx_reset) begin
      state    <= IDLE;
      grant    <= 2'b00;
      busy     <= 1'b0;
      streak   <= '0;
      gap_cnt  <= '0;
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Port 0 wins unless port 1 is also waiting and has been passed over MAX_S0_STREAK times.
          if (s0_axis_tvalid && !(s1_axis_tvalid && streak == STREAK_MAX)) begin
            state  <= GRANT0;
            grant  <= 2'b01;
            busy   <= 1'b1;
            streak <= s1_axis_tvalid ? streak + SW'(1) : '0;
          end else if (s1_axis_tvalid) begin
            state  <= GRANT1;
            grant  <= 2'b10;
            busy   <= 1'b1;
            streak <= '0;
          end
        end
        GRANT0, GRANT1: begin
          if (s0_last_hs || s1_last_hs) begin
            if (s0_last_hs) pkt_cnt0 <= pkt_cnt0 + CNT_WIDTH'(1);
            if (s1_last_hs) pkt_cnt1 <= pkt_cnt1 + CNT_WIDTH'(1);
            grant <= 2'b00;
            if (IFG_CYCLES > 0) begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_stream_arbiter.sv
// Randomized scoreboard bench for tx_stream_arbiter plus a zero-gap instance for bubble timing.
module tb_tx_stream_arbiter;
  localparam int IFG  = 4;
  localparam int MAXS = 4;
  localparam int CW   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [7:0]    s0_tdata, s1_tdata, m_tdata;
  logic          s0_tvalid, s0_tlast, s0_tready;
  logic          s1_tvalid, s1_tlast, s1_tready;
  logic          m_tvalid, m_tlast, m_tready;
  logic [1:0]    grant;
  logic          busy;
  logic [CW-1:0] pkt_cnt0, pkt_cnt1;

  logic [7:0]    z_s0_tdata, z_s1_tdata, z_m_tdata;
  logic          z_s0_tvalid, z_s0_tlast, z_s0_tready;
  logic          z_s1_tvalid, z_s1_tlast, z_s1_tready;
  logic          z_m_tvalid, z_m_tlast, z_m_tready;
  logic [1:0]    z_grant;
  logic          z_busy;
  logic [15:0]   z_cnt0, z_cnt1;

  tx_stream_arbiter #(.DATA_WIDTH(8), .IFG_CYCLES(IFG), .MAX_S0_STREAK(MAXS), .CNT_WIDTH(CW)) u_dut (
    .gtx_clk_bufg(clk), .gtx_reset(rst),
    .s0_axis_tdata(s0_tdata), .s0_axis_tvalid(s0_tvalid), .s0_axis_tlast(s0_tlast), .s0_axis_tready(s0_tready),
    .s1_axis_tdata(s1_tdata), .s1_axis_tvalid(s1_tvalid), .s1_axis_tlast(s1_tlast), .s1_axis_tready(s1_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .grant(grant), .busy(busy), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  tx_stream_arbiter #(.DATA_WIDTH(8), .IFG_CYCLES(0), .MAX_S0_STREAK(MAXS), .CNT_WIDTH(16)) u_dut_ifg0 (
    .gtx_clk_bufg(clk), .gtx_reset(rst),
    .s0_axis_tdata(z_s0_tdata), .s0_axis_tvalid(z_s0_tvalid), .s0_axis_tlast(z_s0_tlast), .s0_axis_tready(z_s0_tready),
    .s1_axis_tdata(z_s1_tdata), .s1_axis_tvalid(z_s1_tvalid), .s1_axis_tlast(z_s1_tlast), .s1_axis_tready(z_s1_tready),
    .m_axis_tdata(z_m_tdata), .m_axis_tvalid(z_m_tvalid), .m_axis_tlast(z_m_tlast), .m_axis_tready(z_m_tready),
    .grant(z_grant), .busy(z_busy), .pkt_cnt0(z_cnt0), .pkt_cnt1(z_cnt1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint expv);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Scoreboard state: expected beats per source, observed packet order, bench-side packet counts.
  logic [8:0] exp0[$];
  logic [8:0] exp1[$];
  int         order_q[$];
  int         sent0 = 0, sent1 = 0;
  int         beats1 = 0;
  longint     cyc = 0;
  longint     last_end_cyc = 0;
  longint     prev_beat_cyc = 0;
  bit         last_end_vld = 0;
  bit         gap_ref_vld = 0;
  bit         exact_gap = 0;
  bit         prev_busy = 0;
  int         cur_port = -1;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    int p;
    logic [8:0] e;
    if (rst) begin
      cur_port = -1; last_end_vld = 0; gap_ref_vld = 0; prev_busy = 0;
    end else begin
      case (grant)
        2'b01: begin
          chk(s0_tready === m_tready, "s0_rdy_mirror", s0_tready, m_tready);
          chk(s1_tready === 1'b0, "s1_rdy_held", s1_tready, 0);
          chk(m_tvalid === s0_tvalid, "m_vld_from_s0", m_tvalid, s0_tvalid);
        end
        2'b10: begin
          chk(s1_tready === m_tready, "s1_rdy_mirror", s1_tready, m_tready);
          chk(s0_tready === 1'b0, "s0_rdy_held", s0_tready, 0);
          chk(m_tvalid === s1_tvalid, "m_vld_from_s1", m_tvalid, s1_tvalid);
        end
        2'b00: chk({m_tvalid, s0_tready, s1_tready} === 3'b000, "idle_quiet", {m_tvalid, s0_tready, s1_tready}, 0);
        default: chk(1'b0, "grant_onehot", grant, 0);
      endcase
      if (grant != 2'b00) chk(busy === 1'b1, "busy_in_grant", busy, 1);
      if (m_tvalid && m_tready) begin
        p = (grant == 2'b10) ? 1 : 0;
        if (cur_port < 0) begin
          if (gap_ref_vld) begin
            if (exact_gap) chk(cyc - last_end_cyc == IFG + 2, "gap_exact", cyc - last_end_cyc, IFG + 2);
            else           chk(cyc - last_end_cyc >= IFG + 2, "gap_min", cyc - last_end_cyc, IFG + 2);
          end
          cur_port = p;
        end else begin
          chk(p == cur_port, "no_interleave", p, cur_port);
          if (exact_gap) chk(cyc == prev_beat_cyc + 1, "contiguous", cyc - prev_beat_cyc, 1);
        end
        prev_beat_cyc = cyc;
        if (p == 0) begin
          if (exp0.size() == 0) chk(1'b0, "exp0_empty", m_tdata, 0);
          else begin e = exp0.pop_front(); chk({m_tlast, m_tdata} === e, "beat_s0", {m_tlast, m_tdata}, e); end
        end else begin
          beats1++;
          if (exp1.size() == 0) chk(1'b0, "exp1_empty", m_tdata, 0);
          else begin e = exp1.pop_front(); chk({m_tlast, m_tdata} === e, "beat_s1", {m_tlast, m_tdata}, e); end
        end
        if (m_tlast) begin
          cur_port = -1; last_end_cyc = cyc; last_end_vld = 1; gap_ref_vld = 1;
          order_q.push_back(p);
        end
      end
      if (prev_busy && !busy)
        chk(last_end_vld && (cyc - last_end_cyc == IFG + 1), "busy_fall", cyc - last_end_cyc, IFG + 1);
      prev_busy = busy;
    end
  end

  task automatic set_src(input int p, input logic v, input logic [7:0] d, input logic l);
    if (p == 0) begin s0_tvalid = v; s0_tdata = d; s0_tlast = l; end
    else        begin s1_tvalid = v; s1_tdata = d; s1_tlast = l; end
  endtask

  // Entered and left at posedge+1; returns early if reset hits mid-packet.
  task automatic drive_pkt(input int p, input int len, input logic [7:0] base, input int max_idle);
    for (int i = 0; i < len; i++) begin
      int idle;
      int waitc;
      bit hs;
      logic [7:0] d;
      idle = (max_idle > 0) ? $urandom_range(0, max_idle) : 0;
      repeat (idle) begin @(posedge clk); #1; end
      d = base + 8'(i);
      set_src(p, 1'b1, d, i == len - 1);
      if (p == 0) exp0.push_back({i == len - 1, d});
      else        exp1.push_back({i == len - 1, d});
      hs = 0; waitc = 0;
      while (!hs) begin
        @(negedge clk);
        if (rst) begin set_src(p, 1'b0, 8'h00, 1'b0); return; end
        hs = (p == 0) ? s0_tready : s1_tready;
        @(posedge clk); #1;
        waitc++;
        if (!hs && waitc > 4000) begin
          chk(1'b0, "handshake_timeout", p, 1);
          set_src(p, 1'b0, 8'h00, 1'b0);
          return;
        end
      end
      set_src(p, 1'b0, 8'h00, 1'b0);
    end
    if (p == 0) sent0++; else sent1++;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (!(exp0.size() == 0 && exp1.size() == 0 && !busy && cur_port < 0) && w < 3000) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 3000) chk(1'b0, "drain_timeout", w, 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic chk_counts();
    chk(pkt_cnt0 == CW'(sent0), "pkt_cnt0", pkt_cnt0, CW'(sent0));
    chk(pkt_cnt1 == CW'(sent1), "pkt_cnt1", pkt_cnt1, CW'(sent1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles expected fewer", cyc);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  int  n0, n1, o0, rem0, rem1, streak, e_port, w;
  bit  d0, d1, stop;

  initial begin
    rst = 1'b1;
    s0_tvalid = 0; s0_tlast = 0; s0_tdata = 8'hA5;
    s1_tvalid = 0; s1_tlast = 0; s1_tdata = 8'h5A;
    m_tready = 1'b1;
    z_s0_tvalid = 0; z_s0_tlast = 0; z_s0_tdata = 8'h3C;
    z_s1_tvalid = 0; z_s1_tlast = 0; z_s1_tdata = 8'h00;
    z_m_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(grant == 2'b00, "rst_grant", grant, 0);
    chk(busy == 1'b0, "rst_busy", busy, 0);
    chk({m_tvalid, m_tlast} == 2'b00, "rst_m_vld_last", {m_tvalid, m_tlast}, 0);
    chk(m_tdata == 8'h00, "rst_m_data", m_tdata, 0);
    chk({s0_tready, s1_tready} == 2'b00, "rst_treadys", {s0_tready, s1_tready}, 0);
    chk(pkt_cnt0 == 0 && pkt_cnt1 == 0, "rst_cnts", {pkt_cnt0, pkt_cnt1}, 0);
    s0_tdata = 8'h00; s1_tdata = 8'h00;
    @(posedge clk); #1 rst = 1'b0;

    // Single 64-byte s1 packet, contiguous.
    exact_gap = 1;
    drive_pkt(1, 64, 8'h00, 0);
    wait_idle();
    chk_counts();

    // Contention: both sources always have 8-byte packets waiting.
    o0 = order_q.size();
    gap_ref_vld = 0;
    fork
      begin for (int k = 0; k < 8; k++) drive_pkt(0, 8, 8'(8'h10 * k), 0); end
      begin for (int k = 0; k < 2; k++) drive_pkt(1, 8, 8'(8'h90 + 8'h10 * k), 0); end
    join
    wait_idle();
    chk(order_q.size() == o0 + 10, "order_len", order_q.size() - o0, 10);
    rem0 = 8; rem1 = 2; streak = 0;
    for (int k = 0; k < 10 && o0 + k < order_q.size(); k++) begin
      if (rem0 > 0 && !(rem1 > 0 && streak == MAXS)) begin
        e_port = 0; rem0--;
        streak = (rem1 > 0) ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
      end else begin
        e_port = 1; rem1--; streak = 0;
      end
      chk(order_q[o0 + k] == e_port, "grant_order", order_q[o0 + k], e_port);
    end
    chk_counts();

    // Backpressure: m_tready toggles every cycle during a 16-byte s0 packet.
    exact_gap = 0;
    stop = 0;
    fork
      begin drive_pkt(0, 16, 8'h00, 0); stop = 1; end
      begin while (!stop) begin m_tready = ~m_tready; @(posedge clk); #1; end m_tready = 1'b1; end
    join
    wait_idle();
    chk_counts();

    // Random traffic on both ports with random downstream stalls.
    for (int r = 0; r < 3; r++) begin
      n0 = $urandom_range(2, 6); n1 = $urandom_range(2, 6);
      d0 = 0; d1 = 0;
      fork
        begin for (int k = 0; k < n0; k++) drive_pkt(0, $urandom_range(1, 12), 8'($urandom), 3); d0 = 1; end
        begin for (int k = 0; k < n1; k++) drive_pkt(1, $urandom_range(1, 12), 8'($urandom), 3); d1 = 1; end
        begin
          while (!(d0 && d1)) begin m_tready = ($urandom_range(0, 3) != 0); @(posedge clk); #1; end
          m_tready = 1'b1;
        end
      join
      wait_idle();
      chk_counts();
    end

    // Reset after byte 10 of a 32-byte s1 packet.
    o0 = beats1;
    fork
      drive_pkt(1, 32, 8'h40, 0);
      begin
        w = 0;
        while (beats1 < o0 + 10 && w < 500) begin @(posedge clk); #1; w++; end
        chk(w < 500, "mid_pkt_wait", w, 0);
        #1 rst = 1'b1;
        #1;
        chk(m_tvalid == 1'b0, "rst_mid_m_vld", m_tvalid, 0);
        chk(grant == 2'b00, "rst_mid_grant", grant, 0);
        chk(pkt_cnt0 == 0 && pkt_cnt1 == 0, "rst_mid_cnts", {pkt_cnt0, pkt_cnt1}, 0);
      end
    join
    exp0.delete(); exp1.delete();
    sent0 = 0; sent1 = 0;
    @(posedge clk); #1 rst = 1'b0;
    drive_pkt(0, 6, 8'h80, 0);
    wait_idle();
    chk_counts();
    chk(order_q[order_q.size() - 1] == 0, "post_rst_port", order_q[order_q.size() - 1], 0);

    // Counter wrap: 15 more single-beat s0 packets brings the total to 16.
    for (int k = 0; k < 15; k++) drive_pkt(0, 1, 8'(8'hC0 + k), 0);
    wait_idle();
    chk(pkt_cnt0 == 0, "cnt_wrap", pkt_cnt0, 0);
    chk_counts();

    // Zero-gap instance: back-to-back single-beat packets give valid on alternate cycles.
    z_m_tready = 1'b1; z_s0_tlast = 1'b1; z_s0_tvalid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!z_m_tvalid && w < 20) begin @(negedge clk); w++; end
    chk(w < 20, "ifg0_start", w, 0);
    for (int i = 0; i < 8; i++) begin
      chk(z_m_tvalid == (i % 2 == 0), "ifg0_vld_pattern", z_m_tvalid, i % 2 == 0);
      chk(z_grant == ((i % 2 == 0) ? 2'b01 : 2'b00), "ifg0_grant", z_grant, (i % 2 == 0) ? 1 : 0);
      if (i % 2 == 0) chk(z_m_tdata == 8'h3C && z_m_tlast, "ifg0_beat", {z_m_tlast, z_m_tdata}, 9'h13C);
      chk(z_s1_tready == 1'b0, "ifg0_s1_rdy", z_s1_tready, 0);
      @(negedge clk);
    end
    z_s0_tvalid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tx_stream_arbiter.md
# tx_stream_arbiter

Packet-granular arbiter that shares the single Ethernet TX byte stream (tx_axis toward the MAC) between two AXI-Stream sources: command-decoder responses on port 0 (high priority) and ADC/radar data frames on port 1. Port 0 wins contention, but a starvation guard forces port 1 through after a bounded run of port-0 packets. A programmable inter-frame gap follows every packet. The block sits between the command decoder/data packetizer outputs and the MAC TX interface, in the gtx_clk_bufg domain.

## Interface
- DATA_WIDTH, 8, tdata width of all streams
- IFG_CYCLES, 4, idle cycles inserted after each packet's last beat (0 allowed)
- MAX_S0_STREAK, 4, consecutive contended port-0 grants before port 1 is forced (≥1)
- CNT_WIDTH, 16, width of per-port packet counters

- gtx_clk_bufg  in  1  clock; all logic is rising-edge
- gtx_reset  in  1  asynchronous, active-high reset
- s0_axis_tdata / tvalid / tlast  in  DATA_WIDTH/1/1  response stream (priority)
- s0_axis_tready  out  1
- s1_axis_tdata / tvalid / tlast  in  DATA_WIDTH/1/1  data stream
- s1_axis_tready  out  1
- m_axis_tdata / tvalid / tlast  out  DATA_WIDTH/1/1  to MAC TX
- m_axis_tready  in  1
- grant  out  2  one-hot current owner ({s1,s0}); 00 when none
- busy  out  1  high in any state except IDLE
- pkt_cnt0, pkt_cnt1  out  CNT_WIDTH  completed packets per port, wrapping

## Operation
- States: IDLE, GRANT0, GRANT1, GAP.
- IDLE: decide on registered-free inputs this cycle:
  - only s0_tvalid → GRANT0; only s1_tvalid → GRANT1;
  - both: GRANT1 if streak == MAX_S0_STREAK, else GRANT0;
  - none → stay.
- Streak counter (width clog2(MAX_S0_STREAK+1)): on port-0 grant with s1_tvalid high → +1 (saturating at MAX_S0_STREAK); on port-0 grant with s1_tvalid low → 0; on port-1 grant → 0.
- GRANTx: m_axis_tdata/tlast = sx fields; m_axis_tvalid = sx_tvalid; sx_tready = m_axis_tready; other port's tready = 0. Combinational pass-through, no buffering. Source may drop tvalid mid-packet; grant held regardless (no timeout).
- Packet end = handshake (valid & ready) with tlast=1: pkt_cntx += 1 (wraps at 2^CNT_WIDTH), next state GAP if IFG_CYCLES>0 else IDLE.
- GAP: gap counter loads IFG_CYCLES-1 on entry, decrements; exit to IDLE when 0. m_axis_tvalid=0, both treadys 0.
- grant is registered, reflects state (GRANT0→01, GRANT1→10, else 00).

## Timing
- Reset (async assert, sync release with clock): state IDLE, grant=00, busy=0, streak=0, gap counter=0, pkt_cnt0=pkt_cnt1=0; combinational outputs m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s0/s1_tready=0.
- Grant latency: tvalid seen in IDLE at edge N → GRANTx after N; first beat can transfer in cycle N+1. Zero-latency data path thereafter.
- Back-to-back: tlast handshake in cycle M → GAP cycles M+1..M+IFG_CYCLES → IDLE at M+IFG_CYCLES+1 → next first beat at M+IFG_CYCLES+2. With IFG_CYCLES=0: exactly one bubble cycle.
- Single-beat packet (tvalid & tlast on first beat) completes in the grant cycle.
- tvalid arriving during GAP or in a GRANT of the other port is held off (tready=0); AXI rule: sources must not deassert tvalid once high without handshake.
- Reset mid-packet: m_axis_tvalid drops immediately; downstream sees a truncated frame without tlast — accepted behaviour, MAC must discard.
- pkt_cnt wrap: 0xFFFF + 1 → 0x0000, no flag.

## Test plan
- Single source: s1 sends 64-byte packet, m_tready=1, IFG=4 → 64 contiguous beats on m_axis, tlast on beat 64, pkt_cnt1=1, grant=10 during, busy low exactly 5 cycles after tlast.
- Contention: s0 and s1 both continuously valid with 8-byte packets, MAX_S0_STREAK=4 → grant order 0,0,0,0,1,0,0,0,0,1…; pkt_cnt0:pkt_cnt1 = 4:1 after 10 packets.
- Backpressure: toggle m_axis_tready 1/0 each cycle during a 16-byte s0 packet → s0_tready mirrors m_tready, data bytes 0x00..0x0F delivered in order, no duplicates/loss, s1_tready stays 0.
- IFG=0 back-to-back single-beat s0 packets → one beat every 2 cycles, m_tvalid pattern 1,0,1,0.
- Reset mid-packet: assert gtx_reset after byte 10 of 32 on s1 → m_tvalid=0 and grant=00 same cycle, counters 0; after release, s0 packet is granted cleanly.
- Counter wrap: force 65536 single-beat s0 packets (or CNT_WIDTH=4, 16 packets) → pkt_cnt0 returns to 0.
